// File: rtl/spi_pkg.sv
// Shared constants for the byte-wide SPI master: FSM encoding, SPI modes, defaults.
package spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int CLK_DIV_DEF = 4;
  localparam int DATA_W_DEF  = 8;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host handshake plus SPI pins of the master, bundled for the top-level port.
interface spi_master_ctrl_if #(parameter int DATA_W = 8);

  logic              start;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;
  logic              ss_n;
  logic              sclk;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, cpol, cpha, data_in, miso,
    output data_out, busy, done, ss_n, sclk, mosi
  );

  modport slave (
    output start, cpol, cpha, data_in, miso,
    input  data_out, busy, done, ss_n, sclk, mosi
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// sclk divider and edge counter. While run is low sclk is parked at level and
// the counters sit at zero, so every transfer starts from a clean phase.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic level,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge,
  output logic last_edge
);

  localparam int EDGES  = 2 * DATA_W;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(EDGES + 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              tc;

  // edge_cnt holds edges already produced, so an even count means the next one is leading
  assign tc         = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign lead_edge  = tc && !edge_cnt[0];
  assign trail_edge = tc && edge_cnt[0];
  assign last_edge  = tc && (edge_cnt == EDGE_W'(EDGES - 1));

  // divider, edge counter and the registered sclk level
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
    end else if (!run) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= level;
    end else if (tc) begin
      div_cnt  <= '0;
      edge_cnt <= edge_cnt + EDGE_W'(1);
      sclk     <= ~sclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Byte-wide SPI master: one full-duplex MSB-first transfer per accepted start.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ss_n high, sclk tracks live cpol, waiting for start
//   ST_SETUP | ss_n low for CLK_DIV cycles before the first sclk edge
//   ST_SHIFT | 16 sclk edges, sample/drive on leading/trailing per cpha
//   ST_HOLD  | ss_n low for CLK_DIV cycles, then done pulse and release
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic               clk,
  input logic               rst,
  spi_master_ctrl_if.master bus
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [1:0]        state;
  logic [DIV_W-1:0]  phase_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [1:0]        cfg_mode;
  logic              ss_n_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] data_out_q;

  logic sclk_run;
  logic sclk_level;
  logic lead_edge;
  logic trail_edge;
  logic last_edge;
  logic sample_now;
  logic drive_now;
  logic phase_tc;

  // In IDLE sclk follows the live cpol pin; once a transfer owns the bus it uses the latched one.
  assign sclk_run   = (state == ST_SHIFT);
  assign sclk_level = (state == ST_IDLE) ? bus.cpol : cfg_mode[1];
  assign phase_tc   = (phase_cnt == DIV_W'(CLK_DIV - 1));

  // cpha=0 samples on leading edges and shifts on trailing ones; cpha=1 is the reverse.
  // The MSB for cpha=0 goes out at start, so the final trailing edge has nothing left to drive.
  assign sample_now = ((cfg_mode == MODE0) || (cfg_mode == MODE2)) ? lead_edge : trail_edge;
  assign drive_now  = ((cfg_mode == MODE1) || (cfg_mode == MODE3)) ? lead_edge
                                                                   : (trail_edge && !last_edge);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (sclk_run),
    .level      (sclk_level),
    .sclk       (bus.sclk),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .last_edge  (last_edge)
  );

  assign bus.ss_n     = ss_n_q;
  assign bus.mosi     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;

  // transfer sequencing, shift registers and all registered host/pin outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      cfg_mode   <= MODE0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          ss_n_q <= 1'b1;
          // the done cycle is already IDLE, so a start there must be ignored explicitly
          if (bus.start && !done_q) begin
            cfg_mode  <= {bus.cpol, bus.cpha};
            rx_sh     <= '0;
            ss_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            phase_cnt <= '0;
            state     <= ST_SETUP;
            if (bus.cpha) begin
              tx_sh <= bus.data_in;
            end else begin
              tx_sh  <= {bus.data_in[DATA_W-2:0], 1'b0};
              mosi_q <= bus.data_in[DATA_W-1];
            end
          end
        end
        ST_SETUP: begin
          if (phase_tc) begin
            phase_cnt <= '0;
            state     <= ST_SHIFT;
          end else begin
            phase_cnt <= phase_cnt + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (sample_now) begin
            rx_sh <= {rx_sh[DATA_W-2:0], bus.miso};
          end
          if (drive_now) begin
            mosi_q <= tx_sh[DATA_W-1];
            tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
          end
          if (last_edge) begin
            phase_cnt <= '0;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (phase_tc) begin
            phase_cnt  <= '0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            data_out_q <= rx_sh;
            mosi_q     <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + DIV_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
